// File: rtl/bitwise_logic_unit.sv
// Pipelined bitwise logic unit: eight bitwise ops over WIDTH bits, registered result with
// zero/parity flags, an internal accumulator and valid/ready handshakes on both sides.
module bitwise_logic_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [WIDTH-1:0] acc,
  output logic [15:0]      ops_done
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic             accept, complete;
  logic [WIDTH-1:0] opa, f;

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign complete  = out_valid && out_ready;

  always_comb begin
    opa = acc_en ? acc : a;
    f   = '0;
    case (op)
      3'b000: f = opa & b;
      3'b001: f = opa | b;
      3'b010: f = ~(opa | b);
      3'b011: f = opa ^ b;
      3'b100: f = ~(opa & b);
      3'b101: f = ~(opa ^ b);
      3'b110: f = ~opa;
      3'b111: f = b;
      default: f = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (accept)
      state_d = FULL;
    else if (complete)
      state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      result   <= '0;
      zero     <= 1'b0;
      parity   <= 1'b0;
      acc      <= '0;
      ops_done <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        result <= f;
        zero   <= (f == '0);
        parity <= ^f;
      end
      // Clear wins, but the accepted op above already consumed the pre-clear acc.
      if (acc_clr)
        acc <= '0;
      else if (accept && acc_en)
        acc <= f;
      if (complete)
        ops_done <= ops_done + 16'd1;
    end
  end

endmodule
